// File: rtl/stash_reader.sv
// stash_reader: on start, walks the Stash circular buffer newest-first through its
// next_sample/sample_out browse port and streams each entry on a valid/ready port.
// The scan issues DEPTH advance pulses, so the Stash pointer ends where it began.
// Optional build macro STASH_READER_STATS_EN adds out_sum/out_max scan statistics.
module stash_reader #(
   parameter int unsigned DEPTH  = 5,
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned SETTLE = 1
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         start,
   input  logic [WIDTH-1:0]                             stash_sample,
   output logic                                         stash_next,
   output logic [WIDTH-1:0]                             out_data,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] out_idx,
   output logic                                         busy,
   output logic                                         done
`ifdef STASH_READER_STATS_EN
   ,
   output logic [WIDTH+$clog2(DEPTH+1)-1:0]             out_sum,
   output logic [WIDTH-1:0]                             out_max
`endif
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PRESENT = 3'd1,
      S_STEP    = 3'd2,
      S_WAIT    = 3'd3,
      S_FIN     = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic              valid_q, valid_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              next_q, next_d;
   logic [CNT_W-1:0]  settle_q, settle_d;
   logic              settle_last;
   logic              idx_last;
   logic              capture;

   assign settle_last = (settle_q == CNT_W'(SETTLE - 1));
   assign idx_last    = (idx_q == IDX_W'(DEPTH - 1));
   // A sample is taken on every edge that enters PRESENT (start accept or settle end)
   assign capture     = (state_d == S_PRESENT) && (state_q != S_PRESENT);

   // State and registered-output flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         data_q   <= '0;
         valid_q  <= 1'b0;
         idx_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         next_q   <= 1'b0;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         idx_q    <= idx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         next_q   <= next_d;
         settle_q <= settle_d;
      end
   end

   // Next-state: start is only looked at in IDLE, so it is ignored while busy
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = S_PRESENT;
         S_PRESENT: if (out_ready) state_d = S_STEP;
         S_STEP:    state_d = S_WAIT;
         S_WAIT:    if (settle_last) state_d = idx_last ? S_FIN : S_PRESENT;
         S_FIN:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output/datapath: pulses are decoded from the next state so they land registered
   always_comb begin
      data_d   = data_q;
      valid_d  = valid_q;
      idx_d    = idx_q;
      busy_d   = busy_q;
      settle_d = settle_q;
      next_d   = (state_d == S_STEP);
      done_d   = (state_d == S_FIN);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d  = '0;
               busy_d = 1'b1;
            end
         end
         S_PRESENT: if (out_ready) valid_d = 1'b0;
         S_STEP:    settle_d = '0;
         S_WAIT: begin
            settle_d = settle_q + CNT_W'(1);
            if (capture) idx_d = idx_q + IDX_W'(1);
         end
         S_FIN: begin
            busy_d = 1'b0;
            idx_d  = '0;
         end
         default: ;
      endcase
      if (capture) begin
         data_d  = stash_sample;
         valid_d = 1'b1;
      end
   end

   assign stash_next = next_q;
   assign out_data   = data_q;
   assign out_valid  = valid_q;
   assign out_idx    = idx_q;
   assign busy       = busy_q;
   assign done       = done_q;

`ifdef STASH_READER_STATS_EN
   localparam int unsigned SUM_W = WIDTH + $clog2(DEPTH + 1);

   logic [SUM_W-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] max_q, max_d;

   // Running sum/max: restart on the start-accept capture, accumulate on later captures
   always_comb begin
      sum_d = sum_q;
      max_d = max_q;
      if (capture) begin
         if (state_q == S_IDLE) begin
            sum_d = SUM_W'(stash_sample);
            max_d = stash_sample;
         end else begin
            sum_d = sum_q + SUM_W'(stash_sample);
            if (stash_sample > max_q) max_d = stash_sample;
         end
      end
   end

   // Statistics flops
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sum_q <= '0;
         max_q <= '0;
      end else begin
         sum_q <= sum_d;
         max_q <= max_d;
      end
   end

   assign out_sum = sum_q;
   assign out_max = max_q;
`endif

endmodule

// File: tb/tb_stash_reader.sv
// tb_stash_reader: randomized self-checking bench for stash_reader with a Stash model.
// Build with STASH_READER_STATS_EN defined to also check out_sum/out_max.
module tb_stash_reader;

   localparam int unsigned DEPTH  = 5;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned SETTLE = 3;
   localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [WIDTH-1:0]  stash_sample;
   logic              stash_next;
   logic [WIDTH-1:0]  out_data;
   logic              out_valid;
   logic              out_ready;
   logic [IW-1:0]     out_idx;
   logic              busy;
   logic              done;
`ifdef STASH_READER_STATS_EN
   logic [WIDTH+$clog2(DEPTH+1)-1:0] out_sum;
   logic [WIDTH-1:0]                 out_max;
`endif

   int checks   = 0;
   int failures = 0;
   int exp_ptr  = 1;

   // Stash model: circular buffer browsed by pointer, advanced by next_sample
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr = PW'(1);
   assign stash_sample = mem[ptr];

   always @(posedge clk) begin
      if (stash_next) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
   end

   always #5 clk = ~clk;

   stash_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stash_sample (stash_sample),
      .stash_next   (stash_next),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_idx      (out_idx),
      .busy         (busy),
      .done         (done)
`ifdef STASH_READER_STATS_EN
      ,
      .out_sum      (out_sum),
      .out_max      (out_max)
`endif
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // One full scan; expectations come from the buffer contents at exp_ptr
   task automatic run_scan(input int bp_idx, input int bp_len, input bit repulse,
                           input bit fin_start, input bit rnd_ready, input bit chk_timing);
      logic [WIDTH-1:0] exp_q [$];
      logic [WIDTH-1:0] v;
      longint exp_sum, exp_max;
      int n, pulses, dones, stall, cyc, last_rise, last_next;
      bit prev_valid, fin, pulsed, rdy;
      exp_sum = 0;
      exp_max = 0;
      for (int k = 0; k < int'(DEPTH); k++) begin
         v = mem[PW'((exp_ptr + k) % int'(DEPTH))];
         exp_q.push_back(v);
         exp_sum += longint'(v);
         if (longint'(v) > exp_max) exp_max = longint'(v);
      end
      n = 0; pulses = 0; dones = 0; stall = 0; cyc = 0;
      last_rise = -1; last_next = -1;
      prev_valid = 1'b0; fin = 1'b0; pulsed = 1'b0;

      start = 1'b1;
      out_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_busy", busy, 1);
`ifdef STASH_READER_STATS_EN
      chk("sum_first", out_sum, exp_q[0]);
`endif
      while (!fin && cyc < 400) begin
         start = 1'b0;
         if (stash_next) begin
            pulses++;
            last_next = cyc;
            chk("next_while_valid", out_valid, 0);
         end
         if (out_valid && !prev_valid) begin
            if (chk_timing && last_rise >= 0) chk("sample_period", cyc - last_rise, 2 + SETTLE);
            if (chk_timing && last_next >= 0) chk("settle_latency", cyc - last_next, SETTLE + 1);
            last_rise = cyc;
         end
         prev_valid = out_valid;
         if (repulse && !pulsed && n == 1 && out_valid) begin
            start = 1'b1;
            pulsed = 1'b1;
         end
         if (done) begin
            dones++;
            chk("done_valid", out_valid, 0);
            chk("done_busy", busy, 1);
`ifdef STASH_READER_STATS_EN
            chk("out_sum", out_sum, exp_sum);
            chk("out_max", out_max, exp_max);
`endif
            if (fin_start) start = 1'b1;
            fin = 1'b1;
         end
         rdy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (out_valid && n == bp_idx && stall < bp_len) begin
            rdy = 1'b0;
            stall++;
         end
         if (out_valid) begin
            if (n < int'(DEPTH)) chk("data", out_data, exp_q[n]);
            chk("idx", out_idx, n);
            if (rdy) n++;
         end
         out_ready = rdy;
         @(posedge clk); #1;
         cyc++;
      end
      if (!fin) chk("scan_timeout", 0, 1);
      start = 1'b0;
      out_ready = 1'b0;
      chk("samples", n, DEPTH);
      chk("next_pulses", pulses, DEPTH);
      chk("done_pulses", dones, 1);
      chk("post_busy", busy, 0);
      chk("post_done", done, 0);
      chk("post_idx", out_idx, 0);
      chk("post_valid", out_valid, 0);
      chk("stash_ptr", ptr, exp_ptr);
      chk("stash_sample", stash_sample, exp_q[0]);
      @(posedge clk); #1;
      chk("idle_next", stash_next, 0);
      chk("idle_busy", busy, 0);
`ifdef STASH_READER_STATS_EN
      chk("sum_held", out_sum, exp_sum);
      chk("max_held", out_max, exp_max);
`endif
   endtask

   initial begin
      int cnt;
      reset = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      // Load 0..6 into a 5-entry Stash: newest (6) sits at index 1
      for (int v = 0; v <= 6; v++) mem[PW'(v % int'(DEPTH))] = WIDTH'(v);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_next", stash_next, 0);
      chk("rst_data", out_data, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Plain scan: 6,2,3,4,5 with timing checks
      run_scan(-1, 0, 1'b0, 1'b0, 1'b0, 1'b1);
      // Backpressure at index 2
      run_scan(2, 3, 1'b0, 1'b0, 1'b0, 1'b0);
      // start re-pulsed mid-scan and in the FIN cycle
      run_scan(-1, 0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset while entry 2 is presented
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt = 0;
      while (!(out_valid && out_idx == IW'(2)) && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      out_ready = 1'b0;
      chk("pre_rst_idx", out_idx, 2);
      chk("pre_rst_data", out_data, 3);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_idx", out_idx, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_next", stash_next, 0);
`ifdef STASH_READER_STATS_EN
      chk("arst_sum", out_sum, 0);
      chk("arst_max", out_max, 0);
`endif
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      exp_ptr = (exp_ptr + 2) % int'(DEPTH);
      chk("rst_stash_ptr", ptr, exp_ptr);
      chk("rst_resume_first", stash_sample, 3);
      // Resumes from the Stash position: 3,4,5,6,2
      run_scan(-1, 0, 1'b0, 1'b0, 1'b0, 1'b1);

      // Randomized contents and consumer behaviour
      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < int'(DEPTH); k++) mem[PW'(k)] = WIDTH'($urandom_range(0, 255));
         run_scan(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 4)),
                  1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), 1'b1, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
